spi_reg_bank: RTL and testbench
===============================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter: ID_VALUE, 16'h5A01, value returned by the read-only ID register.
REQ-002 Parameter: DELAY, 2, simulation delay applied to all registered assignments.
REQ-003 Parameter: SRST_LEN, 16, soft-reset pulse length in clk cycles (range 1..255).
REQ-004 clk  in  1  system clock; single clock domain for the whole block.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 spi_req  in  1  write request from the SPI command stage; held high until spi_ack is seen.
REQ-007 spi_ack  out  1  one-cycle write-accept pulse.
REQ-008 spi_addr  in  7  register address; valid for reads at all times and for writes while spi_req is high.
REQ-009 reg_din  in  16  write data; stable while spi_req is high.
REQ-010 reg_dout  out  16  read data for the current spi_addr.
REQ-011 ctrl_out  out  16  contents of the CTRL register.
REQ-012 status_in  in  16  asynchronous status levels.
REQ-013 event_in  in  4  single-cycle event pulses, synchronous to clk.
REQ-014 err_in  in  8  error pulses, synchronous to clk.
REQ-015 soft_rst_n  out  1  active-low soft reset for downstream logic.

Function
REQ-016 The address map SHALL be: 0x00 ID (RO), 0x01 SCRATCH (RW), 0x02 CTRL (RW), 0x03 STATUS (RO), 0x04-0x07 event counters CNT0-CNT3, 0x08 STICKY, 0x09 SRST; all other addresses read 16'h0000 and ignore writes.
REQ-017 reg_dout SHALL be registered, updated every cycle from spi_addr with one-cycle latency.
REQ-018 The handshake FSM SHALL have three states: IDLE, ACK, WAIT_LOW.
REQ-019 In IDLE with spi_req=1, the FSM SHALL go to ACK; in ACK, spi_ack=1 for exactly that cycle, the write commits, and the FSM goes to WAIT_LOW.
REQ-020 In WAIT_LOW, the FSM SHALL return to IDLE when spi_req=0, so a held request produces exactly one ack and one write.
REQ-021 Writes SHALL use spi_addr and reg_din as sampled in the ACK cycle.
REQ-022 STATUS SHALL read status_in through a 2-flop synchroniser per bit.
REQ-023 CNTn SHALL increment on event_in[n] and saturate at 16'hFFFF without wrapping.
REQ-024 A write of any data to CNTn SHALL clear it to 0; if the clear and an event fall in the same cycle, the clear wins (result 0).
REQ-025 STICKY[7:0] bit i SHALL set on err_in[i]; a written 1 clears bit i (W1C); bits [15:8] read 0.
REQ-026 For STICKY, if set and clear of the same bit fall in the same cycle, set wins.
REQ-027 A write to SRST with bit0=1 SHALL drive soft_rst_n low for SRST_LEN cycles starting the cycle after ACK.
REQ-028 A further SRST write while soft_rst_n is low SHALL restart the count at SRST_LEN.
REQ-029 SRST SHALL read {15'b0, ~soft_rst_n}.
REQ-030 soft_rst_n SHALL NOT reset this block's own registers.

Reset
REQ-031 On rst_n low, asynchronously: FSM=IDLE, spi_ack=0, reg_dout=0, SCRATCH=0, CTRL=0 (so ctrl_out=0), counters=0, STICKY=0, synchronisers=0, soft_rst_n=1, soft-reset counter=0.
REQ-032 Reset asserted mid-handshake SHALL abort the write (no register change); after release, a still-high spi_req is serviced as a new request.

Structure
REQ-033 Register address constants and the ID/reset defaults SHALL live in a shared package/include (spi_reg_defs) also usable by the SPI command stage.
REQ-034 One sub-module, sat_cnt16 (16-bit saturating counter with inc and clr, clr priority), SHALL be instantiated four times; everything else is flat.

Verification
REQ-035 Write 0x01=16'hBEEF with spi_req held 10 cycles -> exactly one spi_ack pulse, one cycle after req rises; reading 0x01 gives 16'hBEEF on reg_dout one cycle after the address is applied.
REQ-036 70000 pulses on event_in[2] -> CNT2 reads 16'hFFFF; a write to 0x06 coinciding with an event -> reads 16'h0000.
REQ-037 err_in=8'h81, then write 0x08=16'h0001 -> reads 16'h0080; W1C on bit 7 in the same cycle as err_in[7] -> bit 7 stays 1.
REQ-038 Write 0x09=1, then write 0x09=1 again 5 cycles later -> soft_rst_n low for 5+SRST_LEN cycles total; 0x09 reads 1 during the pulse and 0 after.
REQ-039 status_in changes to 16'h00F0 -> 0x03 reads 16'h00F0 two or three cycles later; read 0x00 -> ID_VALUE; read 0x7F -> 0.
REQ-040 Assert rst_n in the ACK cycle of a write to CTRL -> ctrl_out=0 after reset; the held spi_req is acked again after release.

Source files
------------

// File: rtl/spi_reg_defs.sv
// ---------------------------------------------------------------------------
// spi_reg_defs
// Shared definitions for the SPI register bank and the SPI command stage.
// It holds the register address map, the ID and reset defaults, the
// handshake FSM state encodings and a small address-decode helper.
// ---------------------------------------------------------------------------
package spi_reg_defs;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 16;

   // Register address map
   localparam logic [6:0] ADDR_ID      = 7'h00;
   localparam logic [6:0] ADDR_SCRATCH = 7'h01;
   localparam logic [6:0] ADDR_CTRL    = 7'h02;
   localparam logic [6:0] ADDR_STATUS  = 7'h03;
   localparam logic [6:0] ADDR_CNT0    = 7'h04;
   localparam logic [6:0] ADDR_CNT3    = 7'h07;
   localparam logic [6:0] ADDR_STICKY  = 7'h08;
   localparam logic [6:0] ADDR_SRST    = 7'h09;

   // ID value and reset defaults
   localparam logic [15:0] ID_DEFAULT  = 16'h5A01;
   localparam logic [15:0] SCRATCH_RST = 16'h0000;
   localparam logic [15:0] CTRL_RST    = 16'h0000;

   // Write-handshake FSM states
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ACK      = 2'd1;
   localparam logic [1:0] ST_WAIT_LOW = 2'd2;

   // True for the four event-counter addresses CNT0..CNT3
   function automatic logic is_cnt_addr(input logic [6:0] addr);
      return (addr >= ADDR_CNT0) && (addr <= ADDR_CNT3);
   endfunction

endpackage

// File: rtl/sat_cnt16.sv
// ---------------------------------------------------------------------------
// sat_cnt16
// A 16-bit event counter that saturates at 16'hFFFF. A clear has priority
// over an increment in the same cycle.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   inc    in   increment request (ignored once saturated)
//   clr    in   synchronous clear, wins over inc
//   cnt    out  current count
// ---------------------------------------------------------------------------
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        clr,
   output logic [15:0] cnt
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 16'h0000;
      end else if (inc && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
// Register bank behind the SPI command stage. Writes arrive through a
// req/ack handshake (one ack and one write per held request); reads are a
// registered mux of spi_addr with one cycle of latency.
// Registers: ID (RO), SCRATCH, CTRL, STATUS (synchronised status_in),
// four saturating event counters (write clears), STICKY error flags (W1C)
// and SRST, which launches a soft-reset pulse on soft_rst_n.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   spi_req     in   write request, held until spi_ack
//   spi_ack     out  one-cycle write-accept pulse
//   spi_addr    in   register address (reads always, writes while spi_req)
//   reg_din     in   write data
//   reg_dout    out  read data for the previous cycle's spi_addr
//   ctrl_out    out  CTRL register contents
//   status_in   in   asynchronous status levels
//   event_in    in   event pulses feeding CNT0..CNT3
//   err_in      in   error pulses feeding STICKY[7:0]
//   soft_rst_n  out  active-low soft reset for downstream logic
// ---------------------------------------------------------------------------
module spi_reg_bank
   import spi_reg_defs::*;
#(
   parameter logic [15:0] ID_VALUE = ID_DEFAULT,
   parameter int          DELAY    = 2,
   parameter int unsigned SRST_LEN = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_req,
   output logic        spi_ack,
   input  logic [6:0]  spi_addr,
   input  logic [15:0] reg_din,
   output logic [15:0] reg_dout,
   output logic [15:0] ctrl_out,
   input  logic [15:0] status_in,
   input  logic [3:0]  event_in,
   input  logic [7:0]  err_in,
   output logic        soft_rst_n
);

   // DELAY only annotates legacy behavioural models; the flops here are
   // zero-delay, so the parameter is carried for interface compatibility.
   if (DELAY < 0) begin : g_delay_compat
   end

   localparam logic [7:0] SRST_LOAD = 8'(SRST_LEN);

   logic [1:0]  state_q,       state_d;
   logic        spi_ack_q,     spi_ack_d;
   logic [15:0] reg_dout_q,    reg_dout_d;
   logic [15:0] scratch_q,     scratch_d;
   logic [15:0] ctrl_q,        ctrl_d;
   logic [15:0] status_meta_q, status_sync_q;
   logic [7:0]  sticky_q,      sticky_d;
   logic [7:0]  srst_cnt_q,    srst_cnt_d;
   logic        soft_rst_n_q,  soft_rst_n_d;

   logic        wr_en;
   logic [3:0]  cnt_clr;
   logic [15:0] cnt [4];

   // ---------------- write handshake ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (spi_req)  state_d = ST_ACK;
         ST_ACK:                    state_d = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!spi_req) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // The write commits during the ACK cycle, using that cycle's addr/data.
   assign wr_en     = (state_q == ST_ACK);
   assign spi_ack_d = (state_d == ST_ACK);

   // ---------------- writable registers ----------------
   always_comb begin
      scratch_d = scratch_q;
      ctrl_d    = ctrl_q;
      if (wr_en && (spi_addr == ADDR_SCRATCH)) scratch_d = reg_din;
      if (wr_en && (spi_addr == ADDR_CTRL))    ctrl_d    = reg_din;
   end

   // W1C is applied first, then new errors are ORed in so a set wins.
   always_comb begin
      sticky_d = sticky_q;
      if (wr_en && (spi_addr == ADDR_STICKY)) sticky_d = sticky_d & ~reg_din[7:0];
      sticky_d = sticky_d | err_in;
   end

   // A new SRST write reloads the full length, even mid-pulse.
   always_comb begin
      srst_cnt_d = srst_cnt_q;
      if (wr_en && (spi_addr == ADDR_SRST) && reg_din[0]) begin
         srst_cnt_d = SRST_LOAD;
      end else if (srst_cnt_q != 8'd0) begin
         srst_cnt_d = srst_cnt_q - 8'd1;
      end
      soft_rst_n_d = (srst_cnt_d == 8'd0);
   end

   // ---------------- event counters ----------------
   for (genvar i = 0; i < 4; i++) begin : g_cnt
      assign cnt_clr[i] = wr_en && (spi_addr == (ADDR_CNT0 + 7'(i)));
      sat_cnt16 u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (event_in[i]),
         .clr   (cnt_clr[i]),
         .cnt   (cnt[i])
      );
   end

   // ---------------- read mux ----------------
   always_comb begin
      reg_dout_d = 16'h0000;
      case (spi_addr)
         ADDR_ID:      reg_dout_d = ID_VALUE;
         ADDR_SCRATCH: reg_dout_d = scratch_q;
         ADDR_CTRL:    reg_dout_d = ctrl_q;
         ADDR_STATUS:  reg_dout_d = status_sync_q;
         ADDR_STICKY:  reg_dout_d = {8'h00, sticky_q};
         ADDR_SRST:    reg_dout_d = {15'b0, ~soft_rst_n_q};
         default: begin
            if (is_cnt_addr(spi_addr)) reg_dout_d = cnt[spi_addr[1:0]];
         end
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         spi_ack_q     <= 1'b0;
         reg_dout_q    <= 16'h0000;
         scratch_q     <= SCRATCH_RST;
         ctrl_q        <= CTRL_RST;
         status_meta_q <= 16'h0000;
         status_sync_q <= 16'h0000;
         sticky_q      <= 8'h00;
         srst_cnt_q    <= 8'd0;
         soft_rst_n_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         spi_ack_q     <= spi_ack_d;
         reg_dout_q    <= reg_dout_d;
         scratch_q     <= scratch_d;
         ctrl_q        <= ctrl_d;
         // Two-flop synchroniser per status bit
         status_meta_q <= status_in;
         status_sync_q <= status_meta_q;
         sticky_q      <= sticky_d;
         srst_cnt_q    <= srst_cnt_d;
         soft_rst_n_q  <= soft_rst_n_d;
      end
   end

   assign spi_ack    = spi_ack_q;
   assign reg_dout   = reg_dout_q;
   assign ctrl_out   = ctrl_q;
   assign soft_rst_n = soft_rst_n_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank
// Stimulus drives one cycle at a time and pushes the expected outputs for
// the following cycle into a scoreboard queue; a monitor on the falling
// edge pops and compares. The reference model tracks register contents as
// plain integers and arrays.
// ---------------------------------------------------------------------------
module tb_spi_reg_bank;

   localparam logic [15:0] ID       = 16'h5A01;
   localparam int          SRST_LEN = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_req = 1'b0;
   logic        spi_ack;
   logic [6:0]  spi_addr = 7'h00;
   logic [15:0] reg_din = 16'h0000;
   logic [15:0] reg_dout;
   logic [15:0] ctrl_out;
   logic [15:0] status_in = 16'h0000;
   logic [3:0]  event_in = 4'h0;
   logic [7:0]  err_in = 8'h00;
   logic        soft_rst_n;

   spi_reg_bank #(.ID_VALUE(ID), .DELAY(2), .SRST_LEN(SRST_LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_req    (spi_req),
      .spi_ack    (spi_ack),
      .spi_addr   (spi_addr),
      .reg_din    (reg_din),
      .reg_dout   (reg_dout),
      .ctrl_out   (ctrl_out),
      .status_in  (status_in),
      .event_in   (event_in),
      .err_in     (err_in),
      .soft_rst_n (soft_rst_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (cyc > 95000) begin
         $display("FAIL watchdog: cycle %0d exceeded limit 95000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   typedef struct {
      int          due;
      logic [15:0] dout;
      logic        ack;
      logic [15:0] ctrl;
      logic        srstn;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // ---------------- reference model ----------------
   logic [15:0] m_scratch, m_ctrl;
   int          m_cnt [4];
   logic [7:0]  m_sticky;
   int          m_rem;
   logic [15:0] m_h1, m_h2;    // status_in one and two cycles ago
   logic        m_armed, m_ack;
   logic [15:0] st_drv = 16'h0000;

   task automatic model_reset();
      m_scratch = 16'h0000;
      m_ctrl    = 16'h0000;
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
      m_sticky  = 8'h00;
      m_rem     = 0;
      m_h1      = 16'h0000;
      m_h2      = 16'h0000;
      m_armed   = 1'b1;
      m_ack     = 1'b0;
   endtask

   function automatic logic [15:0] m_read(input logic [6:0] a);
      case (a)
         7'h00: return ID;
         7'h01: return m_scratch;
         7'h02: return m_ctrl;
         7'h03: return m_h2;
         7'h04, 7'h05, 7'h06, 7'h07: return 16'(m_cnt[int'(a) - 4]);
         7'h08: return {8'h00, m_sticky};
         7'h09: return {15'b0, (m_rem != 0)};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due != cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale_entry: due cycle %0d, now cycle %0d", e.due, cyc);
         end else begin
            chk("reg_dout", reg_dout, e.dout);
            chk("spi_ack", {15'b0, spi_ack}, {15'b0, e.ack});
            chk("ctrl_out", ctrl_out, e.ctrl);
            chk("soft_rst_n", {15'b0, soft_rst_n}, {15'b0, e.srstn});
         end
      end
   end

   // ---------------- stimulus ----------------
   // Drive one cycle's inputs, predict the next cycle's outputs, advance.
   task automatic step(input logic req, input logic [6:0] a, input logic [15:0] d,
                       input logic [3:0] ev, input logic [7:0] er);
      exp_t e;
      logic [7:0] w1c;
      logic ack_n, armed_n;
      spi_req = req; spi_addr = a; reg_din = d;
      event_in = ev; err_in = er; status_in = st_drv;
      e.due  = cyc + 1;
      e.dout = m_read(a);
      for (int n = 0; n < 4; n++) begin
         if (m_ack && (int'(a) == 4 + n)) m_cnt[n] = 0;
         else if (ev[n] && m_cnt[n] < 65535) m_cnt[n] = m_cnt[n] + 1;
      end
      w1c = (m_ack && a == 7'h08) ? d[7:0] : 8'h00;
      m_sticky = (m_sticky & ~w1c) | er;
      if (m_ack && a == 7'h01) m_scratch = d;
      if (m_ack && a == 7'h02) m_ctrl = d;
      if (m_ack && a == 7'h09 && d[0]) m_rem = SRST_LEN;
      else if (m_rem > 0) m_rem = m_rem - 1;
      m_h2 = m_h1;
      m_h1 = st_drv;
      // One ack per request: accept only when armed, re-arm once req drops.
      if (m_ack)        begin ack_n = 1'b0; armed_n = 1'b0; end
      else if (m_armed) begin ack_n = req;  armed_n = !req; end
      else              begin ack_n = 1'b0; armed_n = !req; end
      m_ack = ack_n;
      m_armed = armed_n;
      e.ack   = m_ack;
      e.ctrl  = m_ctrl;
      e.srstn = (m_rem == 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Assert rst_n after the falling edge (mid-cycle), hold n edges, release
   // mid-cycle; the next step() then drives the first post-reset cycle.
   task automatic do_reset(input int n);
      exp_t e;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      for (int k = 0; k < n; k++) begin
         e.due = cyc + 1; e.dout = 16'h0000; e.ack = 1'b0;
         e.ctrl = 16'h0000; e.srstn = 1'b1;
         sb.push_back(e);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wr(input logic [6:0] a, input logic [15:0] d,
                     input logic [3:0] ev, input logic [7:0] er);
      step(1'b1, a, d, ev, er);
      step(1'b1, a, d, ev, er);
      step(1'b0, a, d, ev, er);
   endtask

   initial begin
      model_reset();
      do_reset(3);

      // Held request: one ack, one write, then read back
      repeat (10) step(1'b1, 7'h01, 16'hBEEF, 4'h0, 8'h00);
      step(1'b0, 7'h01, 16'h0000, 4'h0, 8'h00);
      step(1'b0, 7'h01, 16'h0000, 4'h0, 8'h00);
      step(1'b0, 7'h00, 16'h0000, 4'h0, 8'h00);
      step(1'b0, 7'h7F, 16'h0000, 4'h0, 8'h00);
      step(1'b0, 7'h0A, 16'h0000, 4'h0, 8'h00);
      wr(7'h00, 16'h1234, 4'h0, 8'h00);            // RO write ignored
      step(1'b0, 7'h00, 16'h0000, 4'h0, 8'h00);

      // Status through the synchroniser
      st_drv = 16'h00F0;
      repeat (5) step(1'b0, 7'h03, 16'h0000, 4'h0, 8'h00);

      // CNT2 saturation, then clear coinciding with an event
      repeat (70000) step(1'b0, 7'h06, 16'h0000, 4'b0100, 8'h00);
      wr(7'h06, 16'h5555, 4'b0100, 8'h00);
      step(1'b0, 7'h06, 16'h0000, 4'h0, 8'h00);
      step(1'b0, 7'h06, 16'h0000, 4'h0, 8'h00);

      // STICKY set and W1C, then set-wins collision on bit 7
      step(1'b0, 7'h08, 16'h0000, 4'h0, 8'h81);
      wr(7'h08, 16'h0001, 4'h0, 8'h00);
      step(1'b0, 7'h08, 16'h0000, 4'h0, 8'h00);
      wr(7'h08, 16'h0080, 4'h0, 8'h80);
      step(1'b0, 7'h08, 16'h0000, 4'h0, 8'h00);

      // Soft reset pulse, restarted mid-pulse
      wr(7'h09, 16'h0001, 4'h0, 8'h00);
      repeat (2) step(1'b0, 7'h09, 16'h0000, 4'h0, 8'h00);
      wr(7'h09, 16'h0001, 4'h0, 8'h00);
      repeat (SRST_LEN + 6) step(1'b0, 7'h09, 16'h0000, 4'h0, 8'h00);

      // Randomised traffic
      for (int r = 0; r < 300; r++) begin
         logic [6:0]  a;
         logic [15:0] d;
         int hi, lo;
         a  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                           : 7'($urandom_range(0, 11));
         d  = 16'($urandom);
         hi = $urandom_range(2, 6);
         lo = $urandom_range(1, 4);
         for (int k = 0; k < hi; k++) begin
            st_drv = 16'($urandom);
            step(1'b1, a, d, 4'($urandom), 8'($urandom) & 8'($urandom));
         end
         for (int k = 0; k < lo; k++) begin
            st_drv = 16'($urandom);
            step(1'b0, 7'($urandom_range(0, 11)), 16'($urandom), 4'($urandom),
                 8'($urandom) & 8'($urandom));
         end
      end
      repeat (SRST_LEN + 2) step(1'b0, 7'h09, 16'h0000, 4'h0, 8'h00);

      // Reset during the ACK cycle of a CTRL write; held req acked again
      st_drv = 16'h0000;
      step(1'b1, 7'h02, 16'h1234, 4'h0, 8'h00);
      do_reset(2);
      repeat (4) step(1'b1, 7'h02, 16'h1234, 4'h0, 8'h00);
      step(1'b0, 7'h02, 16'h0000, 4'h0, 8'h00);
      step(1'b0, 7'h02, 16'h0000, 4'h0, 8'h00);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
